gpio_filter_bank: RTL and testbench

Multi-channel debounce/glitch filter with edge detection for the GPIO input path. Instantiates `NumCh` independent stability-counter filters, each with its own threshold and enable. Each channel produces a filtered level, single-cycle rise/fall event pulses and sticky, software-clearable event status bits. Sits between the pad input synchronisers and the GPIO interrupt/register logic. It generalises the single-channel counter filter to N channels with per-channel configuration and event capture.

---
 rtl/gpio_filter_bank.sv | 102 ++++++++++
 tb/tb_gpio_filter_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_filter_bank.sv
// gpio_filter_bank: N-channel stability-counter debounce filter with
// rise/fall event pulses and sticky write-1-to-clear event status.
module gpio_filter_bank #(
    parameter int unsigned NumCh    = 8,
    parameter int unsigned CntWidth = 4,
    parameter bit          AsyncOn  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumCh-1:0]          enable_i,
    input  logic [NumCh-1:0]          filter_i,
    input  logic [NumCh*CntWidth-1:0] thresh_i,
    input  logic [NumCh-1:0]          rise_en_i,
    input  logic [NumCh-1:0]          fall_en_i,
    input  logic [NumCh-1:0]          evt_clr_i,
    output logic [NumCh-1:0]          filter_o,
    output logic [NumCh-1:0]          rise_o,
    output logic [NumCh-1:0]          fall_o,
    output logic [NumCh-1:0]          evt_status_o
);

    logic [NumCh-1:0] s;
    logic [NumCh-1:0] sample_q;
    logic [NumCh-1:0] stored_q;
    logic [NumCh-1:0] stored_d;
    logic [NumCh-1:0] out_q;
    logic [NumCh-1:0] status_q;
    logic [NumCh-1:0] status_d;

    if (AsyncOn) begin : g_sync
        logic [NumCh-1:0] sync1_q;
        logic [NumCh-1:0] sync2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= filter_i;
                sync2_q <= sync1_q;
            end
        end

        assign s = sync2_q;
    end else begin : g_nosync
        assign s = filter_i;
    end

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        logic [CntWidth-1:0] thr;
        logic [CntWidth-1:0] ctr_q;
        logic [CntWidth-1:0] ctr_d;

        assign thr = thresh_i[i*CntWidth +: CntWidth];

        // Saturating compare uses >= so a lowered threshold fires at once.
        always_comb begin
            if (s[i] != sample_q[i]) begin
                ctr_d = '0;
            end else if (ctr_q >= thr) begin
                ctr_d = thr;
            end else begin
                ctr_d = ctr_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ctr_q <= '0;
            end else begin
                ctr_q <= ctr_d;
            end
        end

        assign stored_d[i] = (ctr_d == thr) ? s[i] : stored_q[i];
    end

    assign filter_o     = (enable_i & stored_q) | (~enable_i & s);
    assign rise_o       = filter_o & ~out_q;
    assign fall_o       = ~filter_o & out_q;
    assign evt_status_o = status_q;

    // A new event outranks a simultaneous clear.
    assign status_d = (status_q & ~evt_clr_i)
                    | (rise_o & rise_en_i)
                    | (fall_o & fall_en_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
            stored_q <= '0;
            out_q    <= '0;
            status_q <= '0;
        end else begin
            sample_q <= s;
            stored_q <= stored_d;
            out_q    <= filter_o;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_gpio_filter_bank.sv
// Directed bench for gpio_filter_bank: a synchronous-input and an
// async-input instance checked against a queue of expected outputs.
module tb_gpio_filter_bank;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] R   = 4'd1;
    localparam logic [3:0] FA  = 4'd2;
    localparam logic [3:0] ST  = 4'd3;
    localparam logic [3:0] AF  = 4'd4;
    localparam logic [3:0] AR  = 4'd5;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en0, f0, ren0, fen0, clr0;
    logic [31:0] th0;
    logic [7:0]  f0_o, r0_o, fa0_o, st0_o;
    logic [7:0]  en1, f1, ren1, fen1, clr1;
    logic [31:0] th1;
    logic [7:0]  f1_o, r1_o, fa1_o, st1_o;

    exp_t  sbq[$];
    string tagq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    gpio_filter_bank #(.NumCh(8), .CntWidth(4), .AsyncOn(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .filter_i(f0),
        .thresh_i(th0), .rise_en_i(ren0), .fall_en_i(fen0),
        .evt_clr_i(clr0), .filter_o(f0_o), .rise_o(r0_o),
        .fall_o(fa0_o), .evt_status_o(st0_o)
    );

    gpio_filter_bank #(.NumCh(8), .CntWidth(4), .AsyncOn(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .filter_i(f1),
        .thresh_i(th1), .rise_en_i(ren1), .fall_en_i(fen1),
        .evt_clr_i(clr1), .filter_o(f1_o), .rise_o(r1_o),
        .fall_o(fa1_o), .evt_status_o(st1_o)
    );

    function automatic logic [7:0] obs(logic [3:0] sel);
        case (sel)
            4'd0:    return f0_o;
            4'd1:    return r0_o;
            4'd2:    return fa0_o;
            4'd3:    return st0_o;
            4'd4:    return f1_o;
            4'd5:    return r1_o;
            4'd6:    return fa1_o;
            default: return st1_o;
        endcase
    endfunction

    task automatic chk(string tag, logic [3:0] sel,
                       logic [7:0] mask, logic [7:0] val);
        exp_t e;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic cyc();
        exp_t       e;
        string      t;
        logic [7:0] o;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            t = tagq.pop_front();
            o = obs(e.sel) & e.mask;
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, o, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic       prev;
        rst  = 1'b1;
        en0  = 8'hFF; f0 = 8'h00; th0 = 32'h3333_3333;
        ren0 = 8'hF7; fen0 = 8'h08; clr0 = 8'h00;
        en1  = 8'hFF; f1 = 8'h00; th1 = 32'h0000_00F2;
        ren1 = 8'hFF; fen1 = 8'hFF; clr1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_filter", F, 8'hFF, 8'h00);
        chk("rst_rise", R, 8'hFF, 8'h00);
        chk("rst_fall", FA, 8'hFF, 8'h00);
        chk("rst_status", ST, 8'hFF, 8'h00);
        chk("rst_async_filter", AF, 8'hFF, 8'h00);
        cyc();

        // qualification on channel 0
        f0[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("qual_wait", F, 8'h01, 8'h00);
            chk("qual_norise", R, 8'h01, 8'h00);
            cyc();
        end
        chk("qual_level", F, 8'h01, 8'h01);
        chk("qual_rise", R, 8'h01, 8'h01);
        chk("qual_stat_pre", ST, 8'h01, 8'h00);
        cyc();
        chk("qual_rise_end", R, 8'h01, 8'h00);
        chk("qual_status", ST, 8'h01, 8'h01);
        cyc();

        // glitch of 3 cycles on channel 2
        for (int k = 0; k < 9; k++) begin
            f0[2] = (k < 3);
            chk("glitch_filter", F, 8'h04, 8'h00);
            chk("glitch_rise", R, 8'h04, 8'h00);
            chk("glitch_fall", FA, 8'h04, 8'h00);
            chk("glitch_status", ST, 8'h04, 8'h00);
            cyc();
        end

        // channel 3 status via fall events
        f0[3] = 1'b1;
        repeat (4) cyc();
        chk("ch3_rise", R, 8'h08, 8'h08);
        cyc();
        chk("ch3_rise_nostat", ST, 8'h08, 8'h00);
        cyc();
        f0[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ch3_fall_wait", F, 8'h08, 8'h08);
            cyc();
        end
        chk("ch3_fall", FA, 8'h08, 8'h08);
        chk("ch3_fall_level", F, 8'h08, 8'h00);
        cyc();
        chk("ch3_fall_stat", ST, 8'h08, 8'h08);
        chk("ch3_fall_end", FA, 8'h08, 8'h00);
        cyc();
        f0[3] = 1'b1;
        repeat (6) cyc();
        f0[3] = 1'b0;
        repeat (4) cyc();
        clr0 = 8'h08;
        chk("w1c_fall2", FA, 8'h08, 8'h08);
        cyc();
        clr0 = 8'h00;
        chk("w1c_set_wins", ST, 8'h08, 8'h08);
        cyc();
        clr0 = 8'h08;
        chk("w1c_pre_clear", ST, 8'h08, 8'h08);
        cyc();
        clr0 = 8'h00;
        chk("w1c_cleared", ST, 8'h08, 8'h00);
        cyc();
        fen0 = 8'h00;
        f0[3] = 1'b1;
        repeat (6) cyc();
        f0[3] = 1'b0;
        repeat (4) cyc();
        chk("nofen_fall", FA, 8'h08, 8'h08);
        cyc();
        chk("nofen_status", ST, 8'h08, 8'h00);
        cyc();
        chk("nofen_status2", ST, 8'h08, 8'h00);
        cyc();

        // ch1 bypassed, ch0 thresh 0, same toggle pattern
        en0 = 8'hFD;
        th0 = 32'h3333_3330;
        pat = 8'b0101_1001;
        prev = 1'b1;
        for (int k = 0; k < 8; k++) begin
            f0[0] = pat[k];
            f0[1] = pat[k];
            chk("bypass_ch1", F, 8'h02, {6'b0, pat[k], 1'b0});
            chk("thr0_ch0", F, 8'h01, {7'b0, prev});
            cyc();
            prev = pat[k];
        end

        // enabling ch1 while stored differs from input
        f0[1] = 1'b1;
        chk("enbl_bypass", F, 8'h02, 8'h02);
        cyc();
        cyc();
        en0 = 8'hFF;
        chk("enbl_fall", FA, 8'h02, 8'h02);
        chk("enbl_level", F, 8'h02, 8'h00);
        cyc();
        chk("enbl_fall_end", FA, 8'h02, 8'h00);
        chk("enbl_hold", F, 8'h02, 8'h00);
        cyc();
        chk("enbl_requal", F, 8'h02, 8'h02);
        chk("enbl_rise", R, 8'h02, 8'h02);
        cyc();

        // async instance: latency and threshold lowering
        f1 = 8'h03;
        for (int k = 0; k < 5; k++) begin
            chk("async_wait", AF, 8'h03, 8'h00);
            cyc();
        end
        chk("async_level", AF, 8'h01, 8'h01);
        chk("async_rise", AR, 8'h01, 8'h01);
        chk("thr15_hold", AF, 8'h02, 8'h00);
        cyc();
        chk("thr15_hold", AF, 8'h02, 8'h00);
        cyc();
        chk("thr15_hold", AF, 8'h02, 8'h00);
        cyc();
        th1 = 32'h0000_0012;
        chk("thr_drop_same", AF, 8'h02, 8'h00);
        cyc();
        chk("thr_drop_fire", AF, 8'h02, 8'h02);
        chk("thr_drop_rise", AR, 8'h02, 8'h02);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
